// File: rtl/seq_restoring_div_if.sv
// Handshake bundle for seq_restoring_div: start/a/b in, busy/done/q/r/dbz out.
// Master drives the request; slave is the divider.
interface seq_restoring_div_if #(
   parameter int DW = 8,
   parameter int VW = 4
);
   logic          start;
   logic [DW-1:0] a;
   logic [VW-1:0] b;
   logic          busy;
   logic          done;
   logic [DW-1:0] q;
   logic [VW-1:0] r;
   logic          dbz;

   modport master (
      output start, a, b,
      input  busy, done, q, r, dbz
   );

   modport slave (
      input  start, a, b,
      output busy, done, q, r, dbz
   );
endinterface

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider, one quotient bit per clock, with dbz flag.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating).
module seq_restoring_div #(
   parameter  int DW = 8,
   parameter  int VW = 4,
   localparam int CW = $clog2(DW + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_restoring_div_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [VW-1:0] p_q, p_d;
   logic [DW-1:0] w_q, w_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [VW-1:0] b_q, b_d;
   logic [DW-1:0] q_q, q_d;
   logic [VW-1:0] r_q, r_d;
   logic          dbz_q, dbz_d;

   logic [VW:0]   p_sh;
   logic [VW:0]   t;
   logic [VW-1:0] p_nx;
   logic [DW-1:0] w_nx;
   logic [DW-1:0] a_mag;
   logic [VW-1:0] b_mag;
   logic [DW-1:0] q_fin;
   logic [VW-1:0] r_fin;

`ifdef SEQ_DIV_SIGNED_EN
   logic sq_q, sq_d;
   logic sr_q, sr_d;

   // Magnitudes as unsigned; the most negative value maps to itself.
   assign a_mag = bus.a[DW-1] ? -bus.a : bus.a;
   assign b_mag = bus.b[VW-1] ? -bus.b : bus.b;
   assign q_fin = sq_q ? -w_nx : w_nx;
   assign r_fin = sr_q ? -p_nx : p_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_q <= 1'b0;
         sr_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
         sr_q <= sr_d;
      end
   end

   always_comb begin
      sq_d = sq_q;
      sr_d = sr_q;
      if (state_q != S_RUN && bus.start) begin
         sq_d = bus.a[DW-1] ^ bus.b[VW-1];
         sr_d = bus.a[DW-1];
      end
   end
`else
   assign a_mag = bus.a;
   assign b_mag = bus.b;
   assign q_fin = w_nx;
   assign r_fin = p_nx;
`endif

   assign p_sh = {p_q, w_q[DW-1]};
   assign t    = p_sh - {1'b0, b_q};
   assign p_nx = t[VW] ? p_sh[VW-1:0] : t[VW-1:0];
   assign w_nx = {w_q[DW-2:0], ~t[VW]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         w_q     <= '0;
         cnt_q   <= '0;
         b_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         b_q     <= b_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      w_d     = w_q;
      cnt_d   = cnt_q;
      b_d     = b_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               if (bus.b == '0) begin
                  state_d = S_DONE;
                  q_d     = '1;
                  r_d     = '0;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_RUN;
                  p_d     = '0;
                  w_d     = a_mag;
                  b_d     = b_mag;
                  cnt_d   = '0;
               end
            end
         end
         S_RUN: begin
            p_d   = p_nx;
            w_d   = w_nx;
            cnt_d = cnt_q + 1'b1;
            // Results publish on the last iteration edge, together with done.
            if (cnt_q == CW'(DW - 1)) begin
               state_d = S_DONE;
               q_d     = q_fin;
               r_d     = r_fin;
               dbz_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy = (state_q == S_RUN);
   assign bus.done = (state_q == S_DONE);
   assign bus.q    = q_q;
   assign bus.r    = r_q;
   assign bus.dbz  = dbz_q;
endmodule
